// File: rtl/mgnt_reg_endpoint_if.sv
// Management bus between the register hub and one register endpoint.
// The hub drives the request side and the endpoint drives responses and acknowledge.
interface mgnt_reg_endpoint_if;
   logic       req_valid;
   logic       req_wr;
   logic [7:0] req_addr;
   logic [7:0] req_data;
   logic       req_data_valid;
   logic [7:0] resp_data;
   logic       resp_data_valid;
   logic       req_ack;

   modport master (
      output req_valid, req_wr, req_addr, req_data, req_data_valid,
      input  resp_data, resp_data_valid, req_ack
   );

   modport slave (
      input  req_valid, req_wr, req_addr, req_data, req_data_valid,
      output resp_data, resp_data_valid, req_ack
   );
endinterface

// File: rtl/mgnt_reg_endpoint.sv
// Management register endpoint: four control registers, four sampled status words and four
// saturating clear-on-read event counters. Data moves as 4-byte MSB-first streams, and the
// held acknowledge completes each transaction.
module mgnt_reg_endpoint #(
   parameter logic [31:0]  EP_ID    = 32'h0000_0000,
   parameter logic [127:0] CTRL_RST = 128'h0
) (
   input  logic                clk,
   input  logic                rst,
   mgnt_reg_endpoint_if.slave  bus_io,
   output logic [127:0]        ctrl_out_o,
   output logic [3:0]          ctrl_wr_pulse_o,
   input  logic [127:0]        stat_in_i,
   input  logic [3:0]          evt_i
);

   typedef enum logic [2:0] {
      StIdle, StWrRx, StWrCommit, StRdLoad, StRdTx, StAck
   } state_e;

   state_e           state_q;
   logic [2:0]       wr_cnt_q;
   logic [31:0]      wr_shreg_q;
   logic [31:0]      rd_shreg_q;
   logic [1:0]       tx_cnt_q;
   logic [7:0]       resp_data_q;
   logic             resp_valid_q;
   logic             ack_q;
   logic [3:0][31:0] ctrl_q;
   logic [3:0]       pulse_q;
   logic [3:0][31:0] cnt_q, cnt_d;
   logic [3:0]       cnt_clr;
   logic [31:0]      rd_mux;
   logic             wr_capture;

   // Byte capture runs in IDLE too, so the first byte can arrive together with req_valid.
   assign wr_capture = ((state_q == StIdle) || (state_q == StWrRx)) && bus_io.req_valid &&
                       bus_io.req_wr && bus_io.req_data_valid && (wr_cnt_q < 3'd4);

   // Read data selection by address.
   always_comb begin
      rd_mux = '0;
      if (bus_io.req_addr == 8'hFF) begin
         rd_mux = EP_ID;
      end else begin
         case (bus_io.req_addr[7:2])
            6'h00:   rd_mux = ctrl_q[bus_io.req_addr[1:0]];
            6'h04:   rd_mux = stat_in_i[{bus_io.req_addr[1:0], 5'd0} +: 32];
            6'h08:   rd_mux = cnt_q[bus_io.req_addr[1:0]];
            default: rd_mux = '0;
         endcase
      end
   end

   // The counter being read is cleared in the cycle its value is latched.
   always_comb begin
      cnt_clr = '0;
      if ((state_q == StRdLoad) && bus_io.req_valid && (bus_io.req_addr[7:2] == 6'h08)) begin
         cnt_clr[bus_io.req_addr[1:0]] = 1'b1;
      end
   end

   // Counter next state: clear wins, but a coincident event still counts as one.
   always_comb begin
      cnt_d = cnt_q;
      for (int n = 0; n < 4; n++) begin
         if (cnt_clr[n]) begin
            cnt_d[n] = {31'd0, evt_i[n]};
         end else if (evt_i[n] && (cnt_q[n] != 32'hFFFF_FFFF)) begin
            cnt_d[n] = cnt_q[n] + 32'd1;
         end
      end
   end

   // Event counter state.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   // Transaction FSM with registered outputs and control register storage.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= StIdle;
         wr_cnt_q     <= '0;
         wr_shreg_q   <= '0;
         rd_shreg_q   <= '0;
         tx_cnt_q     <= '0;
         resp_data_q  <= '0;
         resp_valid_q <= 1'b0;
         ack_q        <= 1'b0;
         ctrl_q       <= CTRL_RST;
         pulse_q      <= '0;
      end else begin
         pulse_q <= '0;
         if (wr_capture) begin
            wr_shreg_q <= {wr_shreg_q[23:0], bus_io.req_data};
            wr_cnt_q   <= wr_cnt_q + 3'd1;
         end
         case (state_q)
            StIdle: begin
               if (!bus_io.req_valid) begin
                  wr_cnt_q <= '0;
               end else if (bus_io.req_wr) begin
                  state_q <= StWrRx;
               end else begin
                  state_q <= StRdLoad;
               end
            end
            StWrRx: begin
               if (!bus_io.req_valid) begin
                  wr_cnt_q <= '0;
                  state_q  <= StIdle;
               end else if ((wr_cnt_q == 3'd4) || (wr_capture && (wr_cnt_q == 3'd3))) begin
                  state_q <= StWrCommit;
               end
            end
            StWrCommit: begin
               // Non-ctrl addresses are acked but discarded.
               if (bus_io.req_addr[7:2] == 6'h00) begin
                  ctrl_q[bus_io.req_addr[1:0]] <= wr_shreg_q;
                  pulse_q                      <= 4'b0001 << bus_io.req_addr[1:0];
               end
               ack_q   <= bus_io.req_valid;
               state_q <= StAck;
            end
            StRdLoad: begin
               if (!bus_io.req_valid) begin
                  state_q <= StIdle;
               end else begin
                  rd_shreg_q   <= rd_mux;
                  resp_data_q  <= rd_mux[31:24];
                  resp_valid_q <= 1'b1;
                  tx_cnt_q     <= '0;
                  state_q      <= StRdTx;
               end
            end
            StRdTx: begin
               if (!bus_io.req_valid) begin
                  resp_valid_q <= 1'b0;
                  resp_data_q  <= '0;
                  state_q      <= StIdle;
               end else if (tx_cnt_q == 2'd3) begin
                  resp_valid_q <= 1'b0;
                  resp_data_q  <= '0;
                  ack_q        <= 1'b1;
                  state_q      <= StAck;
               end else begin
                  resp_data_q <= rd_shreg_q[23:16];
                  rd_shreg_q  <= {rd_shreg_q[23:0], 8'd0};
                  tx_cnt_q    <= tx_cnt_q + 2'd1;
               end
            end
            StAck: begin
               if (!bus_io.req_valid) begin
                  ack_q    <= 1'b0;
                  wr_cnt_q <= '0;
                  state_q  <= StIdle;
               end else begin
                  ack_q <= 1'b1;
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   assign bus_io.resp_data       = resp_data_q;
   assign bus_io.resp_data_valid = resp_valid_q;
   assign bus_io.req_ack         = ack_q;
   assign ctrl_out_o             = ctrl_q;
   assign ctrl_wr_pulse_o        = pulse_q;

endmodule

// File: tb/tb_mgnt_reg_endpoint.sv
// Bench for mgnt_reg_endpoint: expected read bytes are queued when a read is issued and
// popped as the endpoint streams them; control registers are tracked in a small model.
module tb_mgnt_reg_endpoint;

   localparam logic [31:0]  EpId    = 32'hA5A5_0001;
   localparam logic [127:0] CtrlRst = 128'h4444_4444_3333_3333_2222_2222_1111_1111;

   logic         clk = 1'b0;
   logic         rst;
   logic [127:0] ctrl_out;
   logic [3:0]   ctrl_wr_pulse;
   logic [127:0] stat_in;
   logic [3:0]   evt;

   int           errors = 0;
   int           checks = 0;
   logic [7:0]   exp_q[$];
   logic [31:0]  ctrl_m[4];

   always #5 clk = ~clk;

   mgnt_reg_endpoint_if bus ();

   mgnt_reg_endpoint #(
      .EP_ID    (EpId),
      .CTRL_RST (CtrlRst)
   ) dut (
      .clk             (clk),
      .rst             (rst),
      .bus_io          (bus),
      .ctrl_out_o      (ctrl_out),
      .ctrl_wr_pulse_o (ctrl_wr_pulse),
      .stat_in_i       (stat_in),
      .evt_i           (evt)
   );

   function automatic logic [127:0] ctrl_exp();
      return {ctrl_m[3], ctrl_m[2], ctrl_m[1], ctrl_m[0]};
   endfunction

   task automatic model_reset();
      logic [127:0] r;
      r = CtrlRst;
      for (int n = 0; n < 4; n++) ctrl_m[n] = r[32*n +: 32];
   endtask

   // Full read: queue expected bytes, stream them out, check latency and ack timing.
   task automatic do_read(input logic [7:0] addr, input logic [31:0] exp,
                          input logic [3:0] evt_mask, input string name);
      int         first_v;
      int         ack_at;
      int         nbytes;
      logic [7:0] b;
      for (int k = 3; k >= 0; k--) exp_q.push_back(exp[8*k +: 8]);
      first_v = -1;
      ack_at  = -1;
      nbytes  = 0;
      @(negedge clk);
      bus.req_valid      = 1'b1;
      bus.req_wr         = 1'b0;
      bus.req_addr       = addr;
      bus.req_data_valid = 1'b0;
      for (int i = 1; (i <= 12) && (ack_at < 0); i++) begin
         @(negedge clk);
         if (i == 1) evt = evt | evt_mask;
         if (i == 2) evt = evt & ~evt_mask;
         if (bus.resp_data_valid === 1'b1) begin
            if (first_v < 0) first_v = i;
            nbytes++;
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL %s extra_byte: got %h, required no byte", name, bus.resp_data);
            end else begin
               b = exp_q.pop_front();
               if (bus.resp_data !== b) begin
                  errors++;
                  $display("FAIL %s byte%0d: got %h, required %h", name, nbytes - 1,
                           bus.resp_data, b);
               end
            end
            checks++;
            if (bus.req_ack !== 1'b0) begin
               errors++;
               $display("FAIL %s ack_with_data: got %b, required 0", name, bus.req_ack);
            end
         end
         if (bus.req_ack === 1'b1) ack_at = i;
      end
      checks++;
      if (first_v != 2) begin
         errors++;
         $display("FAIL %s first_byte_cycle: got %0d, required 2", name, first_v);
      end
      checks++;
      if (ack_at != 6) begin
         errors++;
         $display("FAIL %s ack_cycle: got %0d, required 6", name, ack_at);
      end
      checks++;
      if (nbytes != 4) begin
         errors++;
         $display("FAIL %s byte_count: got %0d, required 4", name, nbytes);
      end
      exp_q.delete();
      bus.req_valid = 1'b0;
      @(negedge clk);
      checks++;
      if (bus.req_ack !== 1'b0) begin
         errors++;
         $display("FAIL %s ack_drop: got %b, required 0", name, bus.req_ack);
      end
   endtask

   // Full write, optionally with an idle cycle between data bytes.
   task automatic do_write(input logic [7:0] addr, input logic [31:0] data, input bit gap,
                           input string name);
      logic [3:0] exp_pulse;
      exp_pulse = (addr < 8'd4) ? (4'b0001 << addr[1:0]) : 4'b0000;
      @(negedge clk);
      bus.req_valid = 1'b1;
      bus.req_wr    = 1'b1;
      bus.req_addr  = addr;
      for (int bi = 0; bi < 4; bi++) begin
         if (bi > 0) begin
            @(negedge clk);
            if (gap) begin
               bus.req_data_valid = 1'b0;
               @(negedge clk);
            end
         end
         bus.req_data       = data[8*(3-bi) +: 8];
         bus.req_data_valid = 1'b1;
      end
      @(negedge clk);
      bus.req_data_valid = 1'b0;
      checks++;
      if ((bus.req_ack !== 1'b0) || (ctrl_wr_pulse !== 4'b0000)) begin
         errors++;
         $display("FAIL %s commit_cycle: got ack=%b pulse=%b, required ack=0 pulse=0000",
                  name, bus.req_ack, ctrl_wr_pulse);
      end
      if (addr < 8'd4) ctrl_m[addr[1:0]] = data;
      @(negedge clk);
      checks++;
      if (bus.req_ack !== 1'b1) begin
         errors++;
         $display("FAIL %s ack_rise: got %b, required 1", name, bus.req_ack);
      end
      checks++;
      if (ctrl_wr_pulse !== exp_pulse) begin
         errors++;
         $display("FAIL %s pulse: got %b, required %b", name, ctrl_wr_pulse, exp_pulse);
      end
      checks++;
      if (ctrl_out !== ctrl_exp()) begin
         errors++;
         $display("FAIL %s ctrl_out: got %h, required %h", name, ctrl_out, ctrl_exp());
      end
      @(negedge clk);
      checks++;
      if ((ctrl_wr_pulse !== 4'b0000) || (bus.req_ack !== 1'b1)) begin
         errors++;
         $display("FAIL %s pulse_end: got pulse=%b ack=%b, required pulse=0000 ack=1",
                  name, ctrl_wr_pulse, bus.req_ack);
      end
      bus.req_valid = 1'b0;
      @(negedge clk);
      checks++;
      if (bus.req_ack !== 1'b0) begin
         errors++;
         $display("FAIL %s ack_drop: got %b, required 0", name, bus.req_ack);
      end
   endtask

   task automatic test_reset();
      rst                = 1'b0;
      bus.req_valid      = 1'b0;
      bus.req_wr         = 1'b0;
      bus.req_addr       = 8'h00;
      bus.req_data       = 8'h00;
      bus.req_data_valid = 1'b0;
      evt                = 4'b0000;
      stat_in            = '0;
      model_reset();
      repeat (3) @(negedge clk);
      checks++;
      if ((bus.resp_data !== 8'h00) || (bus.resp_data_valid !== 1'b0) ||
          (bus.req_ack !== 1'b0) || (ctrl_wr_pulse !== 4'b0000)) begin
         errors++;
         $display("FAIL reset_outputs: got data=%h dv=%b ack=%b pulse=%b, required all 0",
                  bus.resp_data, bus.resp_data_valid, bus.req_ack, ctrl_wr_pulse);
      end
      checks++;
      if (ctrl_out !== CtrlRst) begin
         errors++;
         $display("FAIL reset_ctrl: got %h, required %h", ctrl_out, CtrlRst);
      end
      rst = 1'b1;
      repeat (2) @(negedge clk);
      do_read(8'h01, 32'h2222_2222, 4'b0000, "reset_read_ctrl1");
   endtask

   task automatic test_write_ctrl();
      do_write(8'h02, 32'hDEAD_BEEF, 1'b0, "write_ctrl2");
      do_read(8'h02, 32'hDEAD_BEEF, 4'b0000, "read_ctrl2");
   endtask

   task automatic test_counter();
      evt = 4'b0010;
      repeat (5) @(negedge clk);
      evt = 4'b0000;
      do_read(8'h21, 32'd5, 4'b0000, "cnt1_five");
      do_read(8'h21, 32'd0, 4'b0000, "cnt1_cleared");
      evt = 4'b0010;
      repeat (3) @(negedge clk);
      evt = 4'b0000;
      do_read(8'h21, 32'd3, 4'b0010, "cnt1_evt_in_load");
      do_read(8'h21, 32'd1, 4'b0000, "cnt1_after_evt_load");
   endtask

   task automatic test_saturation();
      @(negedge clk);
      evt = 4'b0001;
      force dut.cnt_q = {96'd0, 32'hFFFF_FFFE};
      @(negedge clk);
      release dut.cnt_q;
      repeat (4) @(negedge clk);
      evt = 4'b0000;
      do_read(8'h20, 32'hFFFF_FFFF, 4'b0000, "cnt0_saturated");
      do_read(8'h20, 32'd0, 4'b0000, "cnt0_cleared");
   endtask

   task automatic test_status_id_unmapped();
      stat_in = {32'hCAFE_0003, 32'h0BAD_0002, 32'h1234_5678, 32'h0000_0F00};
      do_read(8'h11, 32'h1234_5678, 4'b0000, "stat1");
      do_read(8'h13, 32'hCAFE_0003, 4'b0000, "stat3");
      do_read(8'hFF, EpId, 4'b0000, "ep_id");
      do_read(8'h50, 32'd0, 4'b0000, "unmapped");
      do_write(8'h10, 32'h0102_0304, 1'b0, "write_stat_discard");
   endtask

   task automatic test_abort();
      bit bad;
      bad = 1'b0;
      @(negedge clk);
      bus.req_valid      = 1'b1;
      bus.req_wr         = 1'b1;
      bus.req_addr       = 8'h01;
      bus.req_data       = 8'h99;
      bus.req_data_valid = 1'b1;
      @(negedge clk);
      bus.req_data       = 8'h88;
      @(negedge clk);
      bus.req_valid      = 1'b0;
      bus.req_data_valid = 1'b0;
      repeat (6) begin
         @(negedge clk);
         if ((bus.req_ack !== 1'b0) || (ctrl_wr_pulse !== 4'b0000)) bad = 1'b1;
      end
      checks++;
      if (bad) begin
         errors++;
         $display("FAIL abort_quiet: got ack or pulse activity, required none");
      end
      checks++;
      if (ctrl_out !== ctrl_exp()) begin
         errors++;
         $display("FAIL abort_ctrl: got %h, required %h", ctrl_out, ctrl_exp());
      end
      do_write(8'h00, 32'h7654_3210, 1'b1, "write_ctrl0_after_abort");
   endtask

   task automatic test_back_to_back();
      do_write(8'h03, 32'hF00D_CAFE, 1'b1, "b2b_write_ctrl3");
      do_read(8'h03, 32'hF00D_CAFE, 4'b0000, "b2b_read_ctrl3");
      do_read(8'h00, 32'h7654_3210, 4'b0000, "b2b_read_ctrl0");
   endtask

   task automatic test_reset_mid_read();
      @(negedge clk);
      bus.req_valid = 1'b1;
      bus.req_wr    = 1'b0;
      bus.req_addr  = 8'h02;
      repeat (3) @(negedge clk);
      checks++;
      if (bus.resp_data_valid !== 1'b1) begin
         errors++;
         $display("FAIL rst_mid_in_tx: got dv=%b, required 1", bus.resp_data_valid);
      end
      #1 rst = 1'b0;
      #1;
      checks++;
      if ((bus.resp_data !== 8'h00) || (bus.resp_data_valid !== 1'b0) ||
          (bus.req_ack !== 1'b0) || (ctrl_wr_pulse !== 4'b0000)) begin
         errors++;
         $display("FAIL rst_mid_outputs: got data=%h dv=%b ack=%b pulse=%b, required all 0",
                  bus.resp_data, bus.resp_data_valid, bus.req_ack, ctrl_wr_pulse);
      end
      checks++;
      if (ctrl_out !== CtrlRst) begin
         errors++;
         $display("FAIL rst_mid_ctrl: got %h, required %h", ctrl_out, CtrlRst);
      end
      model_reset();
      @(negedge clk);
      bus.req_valid = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      do_read(8'h00, 32'h1111_1111, 4'b0000, "rst_mid_read_ctrl0");
   endtask

   initial begin
      test_reset();
      test_write_ctrl();
      test_counter();
      test_saturation();
      test_status_id_unmapped();
      test_abort();
      test_back_to_back();
      test_reset_mid_read();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, required completion");
      $fatal(1, "watchdog expired");
   end

endmodule
